// File: rtl/apb_txn_arbiter_pkg.sv
// Shared definitions for the APB transaction arbiter: FSM state encodings and a
// constant clog2 helper used for index widths.
package apb_txn_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Returns at least 1 so that index vectors never collapse to zero width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: scans upward from i_last+1 (wrapping) and
// returns the first requester as both a one-hot vector and a binary index.
module apb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_oh,
    output logic [IW-1:0] o_idx
);

    logic w_found;
    int   w_cand;

    always_comb begin
        o_oh    = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = int'(i_last) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!w_found && i_req[w_cand]) begin
                w_found        = 1'b1;
                o_oh[w_cand]   = 1'b1;
                o_idx          = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/apb_txn_arbiter.sv
// Multi-master APB arbiter funnelling MASTER_PORTS requesters onto one APB bus.
// Optional ACCESS-phase timeout with error response: define APB_ARB_TIMEOUT_EN.
module apb_txn_arbiter
    import apb_txn_arbiter_pkg::*;
#(
    parameter int MASTER_PORTS   = 4,
    parameter int BUS_WIDTH      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
    input  logic [MASTER_PORTS-1:0]            S_PWRITE,
    input  logic [MASTER_PORTS-1:0]            S_PSELx,
    input  logic [MASTER_PORTS-1:0]            S_PENABLE,
    input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]            S_PREADY,
    output logic [MASTER_PORTS-1:0]            S_PSLVERR,
    output logic [BUS_WIDTH-1:0]               M_PADDR,
    output logic                               M_PWRITE,
    output logic                               M_PSEL,
    output logic                               M_PENABLE,
    output logic [DATA_WIDTH-1:0]              M_PWDATA,
    input  logic [DATA_WIDTH-1:0]              M_PRDATA,
    input  logic                               M_PREADY,
    output logic [MASTER_PORTS-1:0]            grant,
    output logic [clog2(MASTER_PORTS)-1:0]     grant_idx
);

    localparam int IW = clog2(MASTER_PORTS);

    logic [1:0]              r_state;
    logic [1:0]              w_nextState;
    logic [MASTER_PORTS-1:0] r_grant;
    logic [IW-1:0]           r_grantIdx;
    logic [IW-1:0]           r_lastGrant;
    logic [BUS_WIDTH-1:0]    r_paddr;
    logic                    r_pwrite;
    logic [DATA_WIDTH-1:0]   r_pwdata;

    logic [MASTER_PORTS-1:0] w_pickOh;
    logic [IW-1:0]           w_pickIdx;
    logic                    w_award;
    logic                    w_done;
    logic                    w_respond;
    logic                    w_timeout;
    logic                    w_slvErr;
    logic [BUS_WIDTH-1:0]    w_winAddr;
    logic                    w_winWrite;
    logic [DATA_WIDTH-1:0]   w_winWdata;

    // Master-side PENABLE carries no information the arbiter needs.
    logic w_unusedPenable;
    assign w_unusedPenable = ^S_PENABLE;

    apb_rr_pick #(
        .N  (MASTER_PORTS),
        .IW (IW)
    ) u_pick (
        .i_req  (S_PSELx),
        .i_last (r_lastGrant),
        .o_oh   (w_pickOh),
        .o_idx  (w_pickIdx)
    );

    assign w_award = (r_state == ST_IDLE) && (|S_PSELx);
    assign w_done  = M_PREADY || w_timeout;

    always_comb begin
        w_winAddr  = '0;
        w_winWrite = 1'b0;
        w_winWdata = '0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if (w_pickOh[i]) begin
                w_winAddr  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
                w_winWrite = S_PWRITE[i];
                w_winWdata = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (|S_PSELx) w_nextState = ST_SETUP;
            ST_SETUP:  w_nextState = ST_ACCESS;
            ST_ACCESS: if (w_done) w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grantIdx  <= '0;
            r_lastGrant <= IW'(MASTER_PORTS - 1);
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_award) begin
                r_grant     <= w_pickOh;
                r_grantIdx  <= w_pickIdx;
                r_lastGrant <= w_pickIdx;
                r_paddr     <= w_winAddr;
                r_pwrite    <= w_winWrite;
                r_pwdata    <= w_winWdata;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_toCnt;

    // Counts completed ACCESS cycles; the limit fires on the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toCnt <= '0;
        end else if ((r_state == ST_ACCESS) && !w_done) begin
            r_toCnt <= r_toCnt + TW'(1);
        end else begin
            r_toCnt <= '0;
        end
    end

    assign w_timeout = (r_state == ST_ACCESS) && (r_toCnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_slvErr  = w_timeout && !M_PREADY;
`else
    logic w_unusedTimeout;
    assign w_unusedTimeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout       = 1'b0;
    assign w_slvErr        = 1'b0;
`endif

    // Responses are suppressed while rst is high so an aborted transfer never completes.
    assign w_respond = !rst && (r_state == ST_ACCESS) && w_done;

    always_comb begin
        S_PREADY  = '0;
        S_PSLVERR = '0;
        S_PRDATA  = '0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if (w_respond && r_grant[i]) begin
                S_PREADY[i]  = 1'b1;
                S_PSLVERR[i] = w_slvErr;
                S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_PREADY ? M_PRDATA : '0;
            end
        end
    end

    assign M_PSEL    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign M_PENABLE = (r_state == ST_ACCESS);
    assign M_PADDR   = r_paddr;
    assign M_PWRITE  = r_pwrite;
    assign M_PWDATA  = r_pwdata;
    assign grant     = r_grant;
    assign grant_idx = r_grantIdx;

endmodule

// File: tb/tb_apb_txn_arbiter.sv
// Self-checking bench for apb_txn_arbiter; timeout scenarios are exercised when
// APB_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES is then 4).
module tb_apb_txn_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] S_PADDR;
    logic [N-1:0]    S_PWRITE;
    logic [N-1:0]    S_PSELx;
    logic [N-1:0]    S_PENABLE;
    logic [N*DW-1:0] S_PWDATA;
    logic [N*DW-1:0] S_PRDATA;
    logic [N-1:0]    S_PREADY;
    logic [N-1:0]    S_PSLVERR;
    logic [AW-1:0]   M_PADDR;
    logic            M_PWRITE;
    logic            M_PSEL;
    logic            M_PENABLE;
    logic [DW-1:0]   M_PWDATA;
    logic [DW-1:0]   M_PRDATA;
    logic            M_PREADY;
    logic [N-1:0]    grant;
    logic [1:0]      grant_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_txn_arbiter #(
        .MASTER_PORTS   (N),
        .BUS_WIDTH      (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .S_PADDR   (S_PADDR),
        .S_PWRITE  (S_PWRITE),
        .S_PSELx   (S_PSELx),
        .S_PENABLE (S_PENABLE),
        .S_PWDATA  (S_PWDATA),
        .S_PRDATA  (S_PRDATA),
        .S_PREADY  (S_PREADY),
        .S_PSLVERR (S_PSLVERR),
        .M_PADDR   (M_PADDR),
        .M_PWRITE  (M_PWRITE),
        .M_PSEL    (M_PSEL),
        .M_PENABLE (M_PENABLE),
        .M_PWDATA  (M_PWDATA),
        .M_PRDATA  (M_PRDATA),
        .M_PREADY  (M_PREADY),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: who owns the bus and how many cycles since the award.
    bit            mValid = 1'b0;
    bit            mBusy;
    int            mCyc;
    int            mOwner;
    int            mLast;
    logic [N-1:0]  mGrant;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata;
    logic          mWrite;

    always @(posedge clk) begin
        if (rst) begin
            mValid = 1'b1;
            mBusy  = 1'b0;
            mCyc   = 0;
            mOwner = 0;
            mLast  = N - 1;
            mGrant = '0;
            mAddr  = '0;
            mWdata = '0;
            mWrite = 1'b0;
        end else if (mValid) begin
            if (!mBusy) begin
                if (S_PSELx != '0) begin
                    for (int k = N; k >= 1; k--) begin
                        if (S_PSELx[(mLast + k) % N]) mOwner = (mLast + k) % N;
                    end
                    mLast  = mOwner;
                    mGrant = N'(1 << mOwner);
                    mAddr  = S_PADDR[mOwner*AW +: AW];
                    mWdata = S_PWDATA[mOwner*DW +: DW];
                    mWrite = S_PWRITE[mOwner];
                    mBusy  = 1'b1;
                    mCyc   = 1;
                end
            end else if (mCyc == 1) begin
                mCyc = 2;
            end else if (M_PREADY || (TO_EN && (mCyc - 1 == TO))) begin
                mBusy = 1'b0;
            end else begin
                mCyc++;
            end
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            bit            inAccess;
            bit            toHit;
            bit            resp;
            logic [63:0]   expRdata;
            inAccess = mBusy && (mCyc >= 2);
            toHit    = TO_EN && inAccess && (mCyc - 1 == TO);
            resp     = inAccess && (M_PREADY || toHit) && !rst;
            expRdata = (resp && M_PREADY) ? (64'(M_PRDATA) << (mOwner * DW)) : 64'd0;
            checkOutput("M_PSEL",    64'(M_PSEL),    64'(mBusy));
            checkOutput("M_PENABLE", 64'(M_PENABLE), 64'(inAccess));
            checkOutput("M_PADDR",   64'(M_PADDR),   64'(mAddr));
            checkOutput("M_PWRITE",  64'(M_PWRITE),  64'(mWrite));
            checkOutput("M_PWDATA",  64'(M_PWDATA),  64'(mWdata));
            checkOutput("grant",     64'(grant),     64'(mGrant));
            checkOutput("grant_idx", 64'(grant_idx), 64'(mOwner));
            checkOutput("S_PREADY",  64'(S_PREADY),  resp ? 64'(mGrant) : 64'd0);
            checkOutput("S_PSLVERR", 64'(S_PSLVERR), (resp && !M_PREADY) ? 64'(mGrant) : 64'd0);
            checkOutput("S_PRDATA",  64'(S_PRDATA),  expRdata);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [N-1:0] sel, input logic ready, input logic [DW-1:0] rdata);
        S_PSELx  = sel;
        M_PREADY = ready;
        M_PRDATA = rdata;
    endtask

    task automatic resetDut;
        rst = 1'b1;
        applyStimulus('0, 1'b0, '0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    logic [N-1:0] vecSel [4] = '{4'b1010, 4'b0110, 4'b1001, 4'b0011};
    int           vecWait[4] = '{0, 2, 1, 3};
    int           order  [5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        S_PADDR   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        S_PWDATA  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        S_PWRITE  = 4'b0101;
        S_PENABLE = '0;
        resetDut;

        @(negedge clk);
        checkOutput("rst_psel",  64'(M_PSEL),    64'd0);
        checkOutput("rst_grant", 64'(grant),     64'd0);
        checkOutput("rst_idx",   64'(grant_idx), 64'd0);
        checkOutput("rst_paddr", 64'(M_PADDR),   64'd0);

        // Single request, zero-wait slave.
        applyStimulus(4'b0001, 1'b1, 16'hBEEF);
        tick;
        @(negedge clk);
        checkOutput("single_psel_c1",    64'(M_PSEL),    64'd1);
        checkOutput("single_penable_c1", 64'(M_PENABLE), 64'd0);
        tick;
        S_PSELx = '0;
        @(negedge clk);
        checkOutput("single_penable_c2", 64'(M_PENABLE),       64'd1);
        checkOutput("single_pready_c2",  64'(S_PREADY),        64'h1);
        checkOutput("single_prdata",     64'(S_PRDATA[15:0]),  64'hBEEF);
        tick;
        @(negedge clk);
        checkOutput("single_idle_psel",  64'(M_PSEL),          64'd0);

        // Full contention after a fresh reset.
        resetDut;
        applyStimulus(4'b1111, 1'b1, 16'h5A5A);
        for (int k = 0; k < 5; k++) begin
            tick;
            @(negedge clk);
            checkOutput("rr_grant_idx", 64'(grant_idx), 64'(order[k]));
            checkOutput("rr_grant",     64'(grant),     64'(1 << order[k]));
            tick;
            if (k == 4) S_PSELx = '0;
            tick;
        end
        M_PREADY = 1'b0;

`ifndef APB_ARB_TIMEOUT_EN
        // Five wait states from master 1.
        applyStimulus(4'b0010, 1'b0, 16'h1234);
        tick;
        for (int a = 1; a <= 6; a++) begin
            tick;
            if (a == 6) begin
                M_PREADY = 1'b1;
                S_PSELx  = '0;
            end
            @(negedge clk);
            checkOutput("wait_pready", 64'(S_PREADY), (a == 6) ? 64'h2 : 64'h0);
            checkOutput("wait_paddr",  64'(M_PADDR),  64'h2222);
        end
        tick;
        M_PREADY = 1'b0;
        @(negedge clk);
        checkOutput("wait_pready_after", 64'(S_PREADY), 64'h0);
`else
        // Silent slave: the timeout must answer on the 4th ACCESS cycle.
        applyStimulus(4'b0100, 1'b0, 16'hCAFE);
        tick;
        for (int a = 1; a <= 4; a++) begin
            tick;
            if (a == 4) S_PSELx = '0;
            @(negedge clk);
            checkOutput("to_pready", 64'(S_PREADY),  (a == 4) ? 64'h4 : 64'h0);
            checkOutput("to_slverr", 64'(S_PSLVERR), (a == 4) ? 64'h4 : 64'h0);
            checkOutput("to_prdata", 64'(S_PRDATA),  64'h0);
        end
        tick;
        @(negedge clk);
        checkOutput("to_idle_psel", 64'(M_PSEL), 64'd0);
`endif

        // Directed vectors with varied requesters and wait counts.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecSel[v], vecWait[v] == 0, DW'(16'h0F00 + v));
            tick;
            tick;
            for (int w = 0; w < vecWait[v]; w++) tick;
            M_PREADY = 1'b1;
            S_PSELx  = '0;
            tick;
            M_PREADY = 1'b0;
        end

        // Reset while in ACCESS, then a fresh request from master 2.
        applyStimulus(4'b0010, 1'b0, 16'h7777);
        tick;
        tick;
        tick;
        rst      = 1'b1;
        M_PREADY = 1'b1;
        S_PSELx  = '0;
        @(negedge clk);
        checkOutput("abort_pready", 64'(S_PREADY), 64'h0);
        tick;
        rst      = 1'b0;
        M_PREADY = 1'b0;
        @(negedge clk);
        checkOutput("abort_psel",  64'(M_PSEL), 64'd0);
        checkOutput("abort_grant", 64'(grant),  64'd0);
        S_PSELx = 4'b0100;
        tick;
        S_PSELx = '0;
        @(negedge clk);
        checkOutput("fresh_idx",   64'(grant_idx), 64'd2);
        checkOutput("fresh_grant", 64'(grant),     64'h4);
        M_PREADY = 1'b1;
        tick;
        tick;
        applyStimulus(4'b1001, 1'b1, 16'h9999);
        tick;
        S_PSELx = '0;
        @(negedge clk);
        checkOutput("next_idx", 64'(grant_idx), 64'd3);
        tick;
        tick;
        M_PREADY = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_txn_arbiter.md
APB_TXN_ARBITER -- requirements
Module: apb_txn_arbiter

Interface
REQ-001 SHALL have parameter MASTER_PORTS, default 4: number of APB requesters, minimum 2.
REQ-002 SHALL have parameter BUS_WIDTH, default 16: PADDR width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: PWDATA/PRDATA width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: ACCESS-phase wait limit, used only with the timeout feature.
REQ-005 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports S_PADDR, input, MASTER_PORTS*BUS_WIDTH; S_PWRITE, S_PSELx, S_PENABLE, inputs, MASTER_PORTS each; S_PWDATA, input, MASTER_PORTS*DATA_WIDTH: packed master requests.
REQ-008 SHALL have ports S_PRDATA, output, MASTER_PORTS*DATA_WIDTH; S_PREADY and S_PSLVERR, outputs, MASTER_PORTS each: per-master responses.
REQ-009 SHALL have ports M_PADDR, output, BUS_WIDTH; M_PWRITE, M_PSEL, M_PENABLE, outputs, 1 each; M_PWDATA, output, DATA_WIDTH: single APB master toward the interconnect.
REQ-010 SHALL have ports M_PRDATA, input, DATA_WIDTH, and M_PREADY, input, 1: slave response.
REQ-011 SHALL have ports grant, output, MASTER_PORTS, one-hot owner; and grant_idx, output, clog2(MASTER_PORTS), binary owner.

Function
REQ-012 SHALL implement the FSM IDLE->SETUP->ACCESS->IDLE.
REQ-013 In IDLE with any S_PSELx set, SHALL select the winner by round-robin, searching upward from last_grant+1 modulo MASTER_PORTS.
REQ-014 On that edge, SHALL register grant, grant_idx, last_grant and the winner's PADDR/PWRITE/PWDATA into M_PADDR/M_PWRITE/M_PWDATA, and SHALL enter SETUP.
REQ-015 In SETUP, SHALL drive M_PSEL=1 and M_PENABLE=0 for exactly one cycle, then enter ACCESS.
REQ-016 In ACCESS, SHALL drive M_PSEL=1 and M_PENABLE=1 until M_PREADY=1.
REQ-017 In the M_PREADY cycle, SHALL combinationally drive S_PREADY[grant_idx]=1 and S_PRDATA slice grant_idx=M_PRDATA, then enter IDLE.
REQ-018 All non-granted S_PREADY, S_PSLVERR and S_PRDATA slices SHALL be 0 at all times.
REQ-019 Latency: request seen in IDLE at cycle N gives SETUP at N+1, ACCESS at N+2, and earliest S_PREADY at N+2; exactly one IDLE cycle SHALL separate back-to-back transfers.
REQ-020 grant and grant_idx SHALL hold their value through IDLE until the next award.
REQ-021 If the owner drops S_PSELx mid-transfer, the slave transfer SHALL still complete; the response pulse SHALL still be issued.
REQ-022 In IDLE with no requests, M_PSEL and M_PENABLE SHALL be 0.

Reset
REQ-023 When rst=1 at an edge, state SHALL be IDLE, all M_* outputs 0, grant 0, grant_idx 0, last_grant MASTER_PORTS-1, timeout counter 0.
REQ-024 Reset mid-transfer SHALL abort without issuing any S_PREADY.

Configuration
REQ-025 With APB_ARB_TIMEOUT_EN defined, an ACCESS-cycle counter SHALL run. On reaching TIMEOUT_CYCLES without M_PREADY, the block SHALL pulse S_PREADY and S_PSLVERR for the owner with S_PRDATA=0, and return to IDLE.
REQ-026 If M_PREADY and timeout coincide, M_PREADY SHALL win and S_PSLVERR SHALL stay 0.
REQ-027 Without APB_ARB_TIMEOUT_EN, there SHALL be no counter, ACCESS SHALL wait indefinitely, and S_PSLVERR SHALL be tied 0.

Structure
REQ-028 FSM state encodings SHALL live in the shared SoC config header, and clog2 SHALL come from the existing clog2 header.
REQ-029 Round-robin selection SHALL be a combinational sub-module apb_rr_pick (inputs: request vector and last_grant; output: one-hot plus index).

Verification
REQ-030 Single request: S_PSELx=0001, zero-wait slave, M_PRDATA=16'hBEEF -> M_PSEL at cycle 1; M_PENABLE and S_PREADY[0] at cycle 2; S_PRDATA[15:0]=BEEF.
REQ-031 Contention: S_PSELx=1111 held after reset -> grant order 0,1,2,3,0; each transfer 3 cycles.
REQ-032 Wait states: M_PREADY low 5 ACCESS cycles -> S_PREADY exactly one cycle, on the 6th ACCESS cycle; M_PADDR stable throughout.
REQ-033 Timeout (TIMEOUT_CYCLES=4, macro on, M_PREADY=0) -> S_PREADY=S_PSLVERR=1 for the owner on the 4th ACCESS cycle; FSM returns to IDLE.
REQ-034 Reset during ACCESS -> next cycle M_PSEL=0, grant=0; following request from master 2 is granted as if fresh (search starts at 0).
